adder_operand_seq: RTL and testbench
====================================

ADDER_OPERAND_SEQ -- requirements
Module: adder_operand_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand and data-bus width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on the load input, minimum 2.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 din  input  WIDTH: operand byte from the dedicated input pins.
REQ-006 load  input  1: asynchronous pin level; each rising edge requests capture of din.
REQ-007 clear  input  1: synchronous abort and flush, active-high.
REQ-008 op_ready  input  1: downstream adder stage accepts the operand pair.
REQ-009 op_a  output  WIDTH: first captured operand.
REQ-010 op_b  output  WIDTH: second captured operand.
REQ-011 op_valid  output  1: op_a/op_b pair is valid and offered downstream.
REQ-012 busy  output  1: high in any state other than IDLE.
REQ-013 err  output  1: sticky flag, a load edge arrived while the pair was being presented.
REQ-014 xfer_cnt  output  8: count of completed op_valid&op_ready transfers.

Function
REQ-015 load SHALL pass through SYNC_STAGES flops, then a rising-edge detector yielding a 1-cycle load_pulse.
REQ-016 Capture latency: din SHALL be registered on the (SYNC_STAGES+1)th rising clk edge, counting the first edge that samples load high (3rd edge at the default); din must be stable across that edge.
REQ-017 FSM states: IDLE, GOT_A, PRESENT; encoding defined in the package.
REQ-018 IDLE + load_pulse -> op_a<=din, go to GOT_A.
REQ-019 GOT_A + load_pulse -> op_b<=din, go to PRESENT; op_valid rises in the next cycle.
REQ-020 PRESENT: op_valid=1; op_a/op_b SHALL hold stable until transfer.
REQ-021 Transfer = op_valid&op_ready at a clk edge -> go to IDLE, op_valid=0 next cycle, xfer_cnt+1.
REQ-022 xfer_cnt SHALL wrap 255 -> 0 without flagging.
REQ-023 load_pulse in PRESENT SHALL be ignored for data and SHALL set err (including when coincident with a transfer).
REQ-024 load held high SHALL produce exactly one capture; a new capture requires load low for at least SYNC_STAGES cycles.
REQ-025 clear SHALL win over load_pulse and transfer in the same cycle: go to IDLE, op_a=op_b=0, op_valid=0, err=0, no xfer_cnt increment; xfer_cnt is preserved.
REQ-026 op_ready while not PRESENT SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, op_a=0, op_b=0, op_valid=0, busy=0, err=0, xfer_cnt=0, and all synchronizer/edge flops to 0.
REQ-028 Reset asserted mid-operation SHALL discard any partial or presented pair; no transfer is counted.
REQ-029 Deassertion SHALL be synchronized externally to clk; no load pulse may be generated from a load pin already high at reset release until it goes low and high again.

Structure
REQ-030 A shared package adder_pkg SHALL hold the state enum typedef, the default WIDTH constant, and the xfer_cnt width constant.
REQ-031 One sub-module, sync_edge_det (SYNC_STAGES synchronizer + rising-edge detect), SHALL be instantiated once for load.
REQ-032 The FSM, operand registers, err flag, and counter SHALL reside in adder_operand_seq; no combinational path from din to outputs.

Verification
REQ-033 Reset, then load pulses with din=8'h2A then 8'h15 -> op_a=2A, op_b=15, op_valid high; op_ready=1 -> op_valid low next cycle, xfer_cnt=1.
REQ-034 Latency: load rises just before edge E -> op_a updated at edge E+2; op_valid asserted 1 cycle after the second capture edge.
REQ-035 Backpressure: op_ready=0 for 10 cycles with 8'hFF/8'h01 presented -> outputs stable; third load -> err=1, data unchanged; clear -> err=0, IDLE.
REQ-036 Load held high for 20 cycles -> exactly one capture, state GOT_A.
REQ-037 Perform 256 transfers -> xfer_cnt returns to 0; clear coincident with op_ready in PRESENT -> no increment.
REQ-038 rst_n pulsed low in GOT_A and in PRESENT -> all outputs zero immediately; pin load held high through release -> no capture.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the operand sequencer: FSM state encoding,
// default data width and transfer-counter width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int XFER_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT_A   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/adder_operand_seq_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level followed by a rising-edge
// detector that emits a single-cycle pulse per genuine low-to-high transition.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_fill;
  logic              r_prev;
  logic              r_armed;

  // r_fill marks when the synchronizer output reflects a real pin sample
  // rather than reset zeros; the detector only arms after a real low is seen,
  // so a pin already high at reset release cannot produce a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_level};
      r_fill <= {r_fill[STAGES-2:0], 1'b1};
      r_prev <= r_sync[STAGES-1];
      if (r_fill[STAGES-1] && !r_sync[STAGES-1])
        r_armed <= 1'b1;
    end
  end

  assign o_pulse = r_sync[STAGES-1] & ~r_prev & r_armed;

endmodule

// File: rtl/adder_operand_seq.sv
// Collects two operands from a shared input bus on synchronized load edges and
// presents them as a valid/ready pair to the downstream adder stage.
module adder_operand_seq
  import adder_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  op_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic                  op_valid,
  output logic                  busy,
  output logic                  err,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  logic                  w_load_pulse;
  logic                  w_cap_a;
  logic                  w_cap_b;
  logic                  w_set_err;
  logic                  w_count;
  state_e                r_state;
  state_e                w_next_state;
  logic [WIDTH-1:0]      r_op_a;
  logic [WIDTH-1:0]      r_op_b;
  logic                  r_err;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_load_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (load),
    .o_pulse (w_load_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // clear overrides every other event, including a coincident transfer
  always_comb begin
    w_next_state = r_state;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_set_err    = 1'b0;
    w_count      = 1'b0;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_load_pulse) begin
          w_next_state = ST_GOT_A;
          w_cap_a      = 1'b1;
        end
        ST_GOT_A: if (w_load_pulse) begin
          w_next_state = ST_PRESENT;
          w_cap_b      = 1'b1;
        end
        ST_PRESENT: begin
          w_set_err = w_load_pulse;
          if (op_ready) begin
            w_next_state = ST_IDLE;
            w_count      = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_err      <= 1'b0;
      r_xfer_cnt <= '0;
    end else if (clear) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_cap_a)   r_op_a     <= din;
      if (w_cap_b)   r_op_b     <= din;
      if (w_set_err) r_err      <= 1'b1;
      if (w_count)   r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_valid = (r_state == ST_PRESENT);
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_adder_operand_seq.sv
// Scoreboard bench for adder_operand_seq: stimulus pushes expected operand
// pairs, a negedge monitor pops them on each handshake and tracks xfer_cnt.
module tb_adder_operand_seq;
  import adder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       load;
  logic       clear;
  logic       op_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_valid;
  logic       busy;
  logic       err;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] sbq[$];
  logic [7:0]  expCnt = 8'd0;

  adder_operand_seq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .load     (load),
    .clear    (clear),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .busy     (busy),
    .err      (err),
    .xfer_cnt (xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise load long enough for one capture, then hold it low long enough to re-arm
  task automatic applyStimulus(input logic [7:0] value);
    din  = value;
    load = 1'b1;
    tick(3);
    load = 1'b0;
    tick(2);
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      expCnt = 8'd0;
      checkOutput("cnt_in_reset", xfer_cnt, 0);
    end else begin
      checkOutput("xfer_cnt", xfer_cnt, expCnt);
      if (op_valid && op_ready && !clear) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_xfer", 1, 0);
        end else begin
          logic [15:0] exp;
          exp = sbq.pop_front();
          checkOutput("xfer_op_a", op_a, exp[15:8]);
          checkOutput("xfer_op_b", op_b, exp[7:0]);
        end
        expCnt = expCnt + 8'd1;
      end
    end
  end

  initial begin
    din = 8'h00; load = 1'b0; clear = 1'b0; op_ready = 1'b0; rst_n = 1'b0;
    tick(2);
    checkOutput("rst_op_a", op_a, 0);
    checkOutput("rst_op_b", op_b, 0);
    checkOutput("rst_valid", op_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cnt", xfer_cnt, 0);
    rst_n = 1'b1;
    tick(3);

    // Latency: load rises before edge E, op_a appears after edge E+2
    din = 8'h2A; load = 1'b1;
    tick(1);
    checkOutput("lat_E_op_a", op_a, 0);
    tick(1);
    checkOutput("lat_E1_op_a", op_a, 0);
    checkOutput("lat_E1_busy", busy, 0);
    tick(1);
    checkOutput("lat_E2_op_a", op_a, 8'h2A);
    checkOutput("lat_E2_busy", busy, 1);
    checkOutput("lat_E2_valid", op_valid, 0);
    load = 1'b0;
    tick(2);
    applyStimulus(8'h15);
    checkOutput("basic_op_b", op_b, 8'h15);
    checkOutput("basic_valid", op_valid, 1);
    sbq.push_back({8'h2A, 8'h15});
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    checkOutput("basic_valid_drop", op_valid, 0);
    checkOutput("basic_busy", busy, 0);
    checkOutput("basic_cnt", xfer_cnt, 1);

    // Backpressure, error on third load, then clear coincident with op_ready
    applyStimulus(8'hFF);
    applyStimulus(8'h01);
    sbq.push_back({8'hFF, 8'h01});
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("bp_op_a", op_a, 8'hFF);
      checkOutput("bp_op_b", op_b, 8'h01);
      checkOutput("bp_valid", op_valid, 1);
    end
    applyStimulus(8'h77);
    checkOutput("err_set", err, 1);
    checkOutput("err_op_a", op_a, 8'hFF);
    checkOutput("err_op_b", op_b, 8'h01);
    checkOutput("err_valid", op_valid, 1);
    op_ready = 1'b1; clear = 1'b1;
    tick(1);
    op_ready = 1'b0; clear = 1'b0;
    void'(sbq.pop_back());
    checkOutput("clr_err", err, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_op_a", op_a, 0);
    checkOutput("clr_op_b", op_b, 0);
    checkOutput("clr_valid", op_valid, 0);
    checkOutput("clr_cnt", xfer_cnt, 1);

    // Load held high for 20 cycles gives exactly one capture
    din = 8'h33; load = 1'b1;
    tick(5);
    din = 8'h99;
    tick(15);
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_valid", op_valid, 0);
    checkOutput("hold_op_a", op_a, 8'h33);
    load = 1'b0;
    tick(2);
    applyStimulus(8'h44);
    sbq.push_back({8'h33, 8'h44});
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    checkOutput("hold_cnt", xfer_cnt, 2);

    // Reset in GOT_A
    applyStimulus(8'h55);
    checkOutput("gota_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstA_busy", busy, 0);
    checkOutput("rstA_op_a", op_a, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Reset in PRESENT with load held high through release
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    checkOutput("pres_valid", op_valid, 1);
    rst_n = 1'b0; load = 1'b1;
    #1;
    checkOutput("rstP_valid", op_valid, 0);
    checkOutput("rstP_op_a", op_a, 0);
    checkOutput("rstP_op_b", op_b, 0);
    checkOutput("rstP_busy", busy, 0);
    checkOutput("rstP_err", err, 0);
    checkOutput("rstP_cnt", xfer_cnt, 0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    checkOutput("rel_busy", busy, 0);
    checkOutput("rel_op_a", op_a, 0);
    load = 1'b0;
    tick(3);

    // 256 transfers wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i));
      applyStimulus(~8'(i));
      sbq.push_back({8'(i), ~8'(i)});
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
    end
    checkOutput("wrap_cnt", xfer_cnt, 0);
    tick(2);
    checkOutput("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
